// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and memory data-port bundle for load_store_unit
//
// Ports (signals inside the interface):
//   req_valid / req_ready          core request handshake
//   req_we, req_funct3             1 = store; RV32I funct3 (B, H, W, BU, HU)
//   req_addr, req_wdata            byte address and store data
//   rsp_valid, rsp_rdata, rsp_fault one-cycle response pulse with extended load data or fault flag
//   mem_addr, mem_wdata            memory address and store data
//   mem_store, mem_load, mem_byte  memory strobes; mem_byte selects a byte access instead of a word
//   mem_rdata                      combinational memory read data
// Modports: slave = load/store unit side, master = core plus memory side.

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_store;
  logic        mem_load;
  logic        mem_byte;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wdata, mem_store, mem_load, mem_byte
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wdata, mem_store, mem_load, mem_byte
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with alignment check and halfword splitting
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of load_store_unit_if:
//     req_*  one load/store per req_valid & req_ready handshake (accepted only in IDLE)
//     rsp_*  one-cycle response pulse; rsp_rdata sign/zero extended, 0 for stores and faults
//     mem_*  byte/word access port; halfwords are issued as two byte accesses (A, then A+1)

module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_fault;

  logic        w_accept;
  logic        w_fault_req;
  logic        w_half;
  logic        w_word;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_fault;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_store;
  logic        w_mem_load;
  logic        w_mem_byte;

  assign w_req_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = bus.req_valid & w_req_ready;

  // Classify the incoming request; any fault skips memory entirely.
  always_comb begin
    w_fault_req = 1'b0;
    case (bus.req_funct3)
      F3_B:    w_fault_req = 1'b0;
      F3_BU:   w_fault_req = bus.req_we;
      F3_H:    w_fault_req = bus.req_addr[0];
      F3_HU:   w_fault_req = bus.req_we | bus.req_addr[0];
      F3_W:    w_fault_req = (bus.req_addr[1:0] != 2'b00);
      default: w_fault_req = 1'b1;
    endcase
  end

  // Decoded from the latched funct3 so mid-operation changes on req_* are ignored.
  assign w_half = (r_funct3[1:0] == 2'b01);
  assign w_word = (r_funct3 == F3_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_buf    <= 32'h0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_buf    <= 32'h0;
            r_fault  <= w_fault_req;
            r_state  <= w_fault_req ? S_RESP : S_ACC0;
          end
        end
        S_ACC0: begin
          if (!r_we) begin
            r_buf <= w_word ? bus.mem_rdata : {24'h0, bus.mem_rdata[7:0]};
          end
          r_state <= w_half ? S_ACC1 : S_RESP;
        end
        S_ACC1: begin
          // Second half of a halfword load: high byte lands above the low byte.
          if (!r_we) begin
            r_buf[15:8] <= bus.mem_rdata[7:0];
          end
          r_state <= S_RESP;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_rdata = 32'h0;
    w_rsp_fault = 1'b0;
    w_mem_addr  = 32'h0;
    w_mem_wdata = 32'h0;
    w_mem_store = 1'b0;
    w_mem_load  = 1'b0;
    w_mem_byte  = 1'b0;
    case (r_state)
      S_ACC0: begin
        w_mem_addr  = r_addr;
        w_mem_byte  = ~w_word;
        w_mem_load  = ~r_we;
        w_mem_store = r_we;
        if (r_we) begin
          w_mem_wdata = w_word ? r_wdata : {24'h0, r_wdata[7:0]};
        end
      end
      S_ACC1: begin
        // A[0] is 0 for any halfword that got here, so A+1 never carries.
        w_mem_addr  = {r_addr[31:1], 1'b1};
        w_mem_byte  = 1'b1;
        w_mem_load  = ~r_we;
        w_mem_store = r_we;
        if (r_we) begin
          w_mem_wdata = {24'h0, r_wdata[15:8]};
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_rsp_fault = r_fault;
        if (!r_fault && !r_we) begin
          case (r_funct3)
            F3_B:    w_rsp_rdata = {{24{r_buf[7]}}, r_buf[7:0]};
            F3_BU:   w_rsp_rdata = {24'h0, r_buf[7:0]};
            F3_H:    w_rsp_rdata = {{16{r_buf[15]}}, r_buf[15:0]};
            F3_HU:   w_rsp_rdata = {16'h0, r_buf[15:0]};
            F3_W:    w_rsp_rdata = r_buf;
            default: w_rsp_rdata = 32'h0;
          endcase
        end
      end
      default: begin
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_rdata;
  assign bus.rsp_fault = w_rsp_fault;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_store = w_mem_store;
  assign bus.mem_load  = w_mem_load;
  assign bus.mem_byte  = w_mem_byte;

endmodule
